// File: rtl/s100_io_reg_bridge_if.sv
// S100/Z80 I/O bus bundle between the CPU side (master) and the register
// bridge (slave). Carries the port address, write data, the two active-low
// strobes and the bridge's read data, output enable and wait line.
interface s100_io_reg_bridge_if;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic       cpu_iowr_n;
  logic       cpu_iord_n;
  logic [7:0] cpu_data_out;
  logic       cpu_data_oe;
  logic       cpu_wait_n;

  modport master (
    output cpu_addr,
    output cpu_data_in,
    output cpu_iowr_n,
    output cpu_iord_n,
    input  cpu_data_out,
    input  cpu_data_oe,
    input  cpu_wait_n
  );

  modport slave (
    input  cpu_addr,
    input  cpu_data_in,
    input  cpu_iowr_n,
    input  cpu_iord_n,
    output cpu_data_out,
    output cpu_data_oe,
    output cpu_wait_n
  );
endinterface

// File: rtl/s100_io_reg_bridge.sv
// Bridges Z80/S100 I/O cycles onto an 8-bit x NUM_REGS register file.
// The asynchronous CPU strobes are synchronised, the port window decoded,
// wait states inserted, and exactly one register-file write pulse issued per
// OUT. Read data is captured from the register file's async read port.
//
// Optional feature: define REGBRIDGE_INDIRECT_EN to replace the direct port
// window with an index port (BASE_PORT) and a data port (BASE_PORT+1) whose
// index post-increments after every data access.
module s100_io_reg_bridge #(
  parameter logic [7:0] BASE_PORT   = 8'h30,
  parameter int         NUM_REGS    = 16,
  parameter int         INDEX_WIDTH = $clog2(NUM_REGS),
  parameter int         SYNC_STAGES = 2,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  s100_io_reg_bridge_if.slave    cpu,
  output logic                   rf_write_en,
  output logic [INDEX_WIDTH-1:0] rf_write_addr,
  output logic [7:0]             rf_write_data,
  output logic [INDEX_WIDTH-1:0] rf_read_addr,
  input  logic [7:0]             rf_read_data
);

  localparam int CNT_WIDTH = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_COMMIT,
    RD_WAIT,
    HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic                   wr_prev_q, wr_prev_d;
  logic                   rd_prev_q, rd_prev_d;
  logic                   rd_access_q, rd_access_d;
  logic                   write_en_q, write_en_d;
  logic [INDEX_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [7:0]             write_data_q, write_data_d;
  logic [INDEX_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_oe_q, data_oe_d;
  logic                   wait_n_q, wait_n_d;

  logic wr_synced, rd_synced;
  logic wr_fall, rd_fall;
  logic hit;

`ifdef REGBRIDGE_INDIRECT_EN
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   index_access_q, index_access_d;
  logic                   is_index_port;
  logic [INDEX_WIDTH-1:0] index_next;
  logic [INDEX_WIDTH-1:0] index_from_data;
`else
  logic [INDEX_WIDTH-1:0] offset;
`endif

  // Shift the raw strobes into the synchroniser chains and detect falling edges
  always_comb begin
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], cpu.cpu_iowr_n};
    rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], cpu.cpu_iord_n};
    wr_synced = wr_sync_q[SYNC_STAGES-1];
    rd_synced = rd_sync_q[SYNC_STAGES-1];
    wr_prev_d = wr_synced;
    rd_prev_d = rd_synced;
    wr_fall   = wr_prev_q & ~wr_synced;
    rd_fall   = rd_prev_q & ~rd_synced;
  end

  // Decide whether the current port address belongs to this bridge
  always_comb begin
`ifdef REGBRIDGE_INDIRECT_EN
    is_index_port   = (cpu.cpu_addr == BASE_PORT);
    hit             = is_index_port || (cpu.cpu_addr == (BASE_PORT + 8'd1));
    index_next      = (index_q == INDEX_WIDTH'(NUM_REGS - 1)) ? '0 : index_q + 1'b1;
    index_from_data = INDEX_WIDTH'(32'(cpu.cpu_data_in) % NUM_REGS);
`else
    hit    = ({1'b0, cpu.cpu_addr} >= {1'b0, BASE_PORT}) &&
             ({1'b0, cpu.cpu_addr} <  ({1'b0, BASE_PORT} + 9'(NUM_REGS)));
    offset = INDEX_WIDTH'(cpu.cpu_addr - BASE_PORT);
`endif
  end

  // Access sequencer: next state plus the registered bus and register-file outputs
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    rd_access_d  = rd_access_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    read_addr_d  = read_addr_q;
    data_out_d   = data_out_q;
    data_oe_d    = data_oe_q;
    wait_n_d     = wait_n_q;
`ifdef REGBRIDGE_INDIRECT_EN
    index_d        = index_q;
    index_access_d = index_access_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (hit && wr_fall && rd_synced) begin
          state_d     = WR_WAIT;
          wait_cnt_d  = '0;
          wait_n_d    = 1'b0;
          rd_access_d = 1'b0;
`ifdef REGBRIDGE_INDIRECT_EN
          index_access_d = is_index_port;
          if (is_index_port) begin
            index_d = index_from_data;
          end else begin
            write_addr_d = index_q;
            write_data_d = cpu.cpu_data_in;
            index_d      = index_next;
          end
`else
          write_addr_d = offset;
          write_data_d = cpu.cpu_data_in;
`endif
        end else if (hit && rd_fall && wr_synced) begin
          state_d     = RD_WAIT;
          wait_cnt_d  = '0;
          wait_n_d    = 1'b0;
          data_oe_d   = 1'b1;
          rd_access_d = 1'b1;
`ifdef REGBRIDGE_INDIRECT_EN
          index_access_d = is_index_port;
          if (!is_index_port) begin
            read_addr_d = index_q;
            index_d     = index_next;
          end
`else
          read_addr_d = offset;
`endif
        end
      end

      WR_WAIT: begin
        if (wait_cnt_q == CNT_LAST) begin
          state_d    = WR_COMMIT;
          wait_cnt_d = '0;
          wait_n_d   = 1'b1;
`ifdef REGBRIDGE_INDIRECT_EN
          write_en_d = ~index_access_q;
`else
          write_en_d = 1'b1;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      WR_COMMIT: begin
        state_d = HOLD;
      end

      RD_WAIT: begin
`ifdef REGBRIDGE_INDIRECT_EN
        data_out_d = index_access_q ? 8'(index_q) : rf_read_data;
`else
        data_out_d = rf_read_data;
`endif
        if (wait_cnt_q == CNT_LAST) begin
          state_d    = HOLD;
          wait_cnt_d = '0;
          wait_n_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (rd_access_q ? rd_synced : wr_synced) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      wr_sync_q    <= '1;
      rd_sync_q    <= '1;
      wr_prev_q    <= 1'b1;
      rd_prev_q    <= 1'b1;
      rd_access_q  <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      read_addr_q  <= '0;
      data_out_q   <= '0;
      data_oe_q    <= 1'b0;
      wait_n_q     <= 1'b1;
`ifdef REGBRIDGE_INDIRECT_EN
      index_q        <= '0;
      index_access_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      wr_sync_q    <= wr_sync_d;
      rd_sync_q    <= rd_sync_d;
      wr_prev_q    <= wr_prev_d;
      rd_prev_q    <= rd_prev_d;
      rd_access_q  <= rd_access_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      read_addr_q  <= read_addr_d;
      data_out_q   <= data_out_d;
      data_oe_q    <= data_oe_d;
      wait_n_q     <= wait_n_d;
`ifdef REGBRIDGE_INDIRECT_EN
      index_q        <= index_d;
      index_access_q <= index_access_d;
`endif
    end
  end

  assign cpu.cpu_data_out = data_out_q;
  assign cpu.cpu_data_oe  = data_oe_q;
  assign cpu.cpu_wait_n   = wait_n_q;
  assign rf_write_en      = write_en_q;
  assign rf_write_addr    = write_addr_q;
  assign rf_write_data    = write_data_q;
  assign rf_read_addr     = read_addr_q;

endmodule
